da_z1_sequencer: RTL and testbench

Bit-serial distributed-arithmetic controller for the Z1 (first odd-row) output of the 8-point DCT. It accepts one 4-sample odd-difference vector (x0..x3) through a valid/ready handshake and walks its bit-planes MSB-first. For each bit-plane it drives the 3-bit address and chip select of the Z1 coefficient ROM, shift-accumulates the returned Q2.14 partial sums, and applies the offset-binary correction. It presents the signed Z1 result through a valid/ready output handshake.

---
 rtl/da_z1_sequencer.sv | 173 +++++++++++++++++
 tb/tb_da_z1_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/da_z1_sequencer.sv
// Bit-serial distributed-arithmetic controller for the Z1 row of the 8-point DCT.
// Walks the four odd-difference samples MSB-first against an offset-binary coefficient ROM.
module da_z1_sequencer #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 36
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x0,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] x2,
    input  logic signed [DATA_W-1:0] x3,
    output logic                     rom_cs,
    output logic [2:0]               rom_addr,
    input  logic signed [COEF_W-1:0] rom_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  z1
);

    localparam int JW = $clog2(DATA_W);
    localparam logic [JW-1:0] J_TOP = JW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        OFFSET = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                   state_r, state_nxt_s;
    logic [DATA_W-1:0]        sr0_r, sr1_r, sr2_r, sr3_r;
    logic [JW-1:0]            j_r;
    logic signed [ACC_W-1:0]  acc_r, z1_r;
    logic                     in_ready_r, out_valid_r, rom_cs_r;
    logic [2:0]               rom_addr_r;
    logic                     rom_cs_nxt_s, in_ready_nxt_s, out_valid_nxt_s;
    logic [2:0]               rom_addr_nxt_s;
    logic                     accept_s, last_s;
    logic signed [ACC_W-1:0]  rom_ext_s, g_s, term_s, acc_shift_s, acc_offset_s;

    // Bit 0 selects the mirrored half of the ROM, which is stored only for b0=0.
    function automatic logic [2:0] addr_f(input logic b0, input logic b1,
                                          input logic b2, input logic b3);
        logic [2:0] a;
        a = {b1, b2, b3};
        return b0 ? ~a : a;
    endfunction

    assign accept_s = (state_r == IDLE) && in_valid;
    assign last_s   = (j_r == {JW{1'b0}});

    assign rom_ext_s    = {{(ACC_W-COEF_W){rom_data[COEF_W-1]}}, rom_data};
    assign g_s          = sr0_r[DATA_W-1] ? -rom_ext_s : rom_ext_s;
    assign term_s       = (j_r == J_TOP) ? g_s : -g_s;
    assign acc_shift_s  = (acc_r <<< 1) + term_s;
    assign acc_offset_s = acc_r - rom_ext_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = accept_s ? SHIFT : IDLE;
            SHIFT:   state_nxt_s = last_s ? OFFSET : SHIFT;
            OFFSET:  state_nxt_s = DONE;
            DONE:    state_nxt_s = out_ready ? IDLE : DONE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; the ROM address leads the data it selects by one edge.
    always_comb begin
        rom_cs_nxt_s    = 1'b0;
        rom_addr_nxt_s  = 3'b000;
        in_ready_nxt_s  = (state_nxt_s == IDLE);
        out_valid_nxt_s = (state_nxt_s == DONE);
        case (state_nxt_s)
            SHIFT: begin
                rom_cs_nxt_s = 1'b1;
                if (state_r == IDLE) begin
                    rom_addr_nxt_s = addr_f(x0[DATA_W-1], x1[DATA_W-1],
                                            x2[DATA_W-1], x3[DATA_W-1]);
                end else begin
                    rom_addr_nxt_s = addr_f(sr0_r[DATA_W-2], sr1_r[DATA_W-2],
                                            sr2_r[DATA_W-2], sr3_r[DATA_W-2]);
                end
            end
            OFFSET: begin
                rom_cs_nxt_s   = 1'b1;
                rom_addr_nxt_s = 3'b000;
            end
            default: begin
                rom_cs_nxt_s   = 1'b0;
                rom_addr_nxt_s = 3'b000;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            rom_cs_r    <= 1'b0;
            rom_addr_r  <= 3'b000;
        end else begin
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            rom_cs_r    <= rom_cs_nxt_s;
            rom_addr_r  <= rom_addr_nxt_s;
        end
    end

    // Shift registers, bit counter and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr0_r <= {DATA_W{1'b0}};
            sr1_r <= {DATA_W{1'b0}};
            sr2_r <= {DATA_W{1'b0}};
            sr3_r <= {DATA_W{1'b0}};
            j_r   <= {JW{1'b0}};
            acc_r <= {ACC_W{1'b0}};
            z1_r  <= {ACC_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sr0_r <= x0;
                        sr1_r <= x1;
                        sr2_r <= x2;
                        sr3_r <= x3;
                        j_r   <= J_TOP;
                        acc_r <= {ACC_W{1'b0}};
                    end
                end
                SHIFT: begin
                    sr0_r <= sr0_r << 1;
                    sr1_r <= sr1_r << 1;
                    sr2_r <= sr2_r << 1;
                    sr3_r <= sr3_r << 1;
                    j_r   <= j_r - JW'(1);
                    acc_r <= acc_shift_s;
                end
                OFFSET: begin
                    acc_r <= acc_offset_s;
                    z1_r  <= acc_offset_s;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign rom_cs    = rom_cs_r;
    assign rom_addr  = rom_addr_r;
    assign z1        = z1_r;

endmodule

// File: tb/tb_da_z1_sequencer.sv
// Directed bench for da_z1_sequencer with a behavioural offset-binary Z1 ROM.
module tb_da_z1_sequencer;

    localparam int C7 = 3195;
    localparam int C5 = 9103;
    localparam int C3 = 13623;
    localparam int C1 = 16069;

    logic               clk, rst_n, in_valid, in_ready, rom_cs, out_valid, out_ready;
    logic signed [15:0] x0, x1, x2, x3, rom_data;
    logic [2:0]         rom_addr;
    logic signed [35:0] z1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic signed [15:0] x0, x1, x2, x3;
        longint             z1;
    } vec_t;

    da_z1_sequencer #(.DATA_W(16), .COEF_W(16), .ACC_W(36)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .z1(z1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM word for address {b1,b2,b3} with b0=0: half of (c7 - sum c_k*d_k), d_k = +/-1.
    function automatic logic signed [15:0] rom_f(input logic [2:0] a);
        int d1, d2, d3, v;
        d1 = a[2] ? 1 : -1;
        d2 = a[1] ? 1 : -1;
        d3 = a[0] ? 1 : -1;
        v = (C7 - C5 * d1 - C3 * d2 - C1 * d3) / 2;
        return 16'(v);
    endfunction

    always_comb rom_data = rom_f(rom_addr);

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present a vector at the next idle slot; returns after the accept edge.
    task automatic accept_vec(input vec_t v);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", longint'(in_ready), 1);
        x0 = v.x0; x1 = v.x1; x2 = v.x2; x3 = v.x3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x0 = 16'(int'($urandom)); x1 = 16'(int'($urandom));
        x2 = 16'(int'($urandom)); x3 = 16'(int'($urandom));
    endtask

    // Wait for out_valid counting cycles after the accept; lat is 1 on entry.
    task automatic wait_result(input string name, input longint exp, input bit chk_addr);
        int lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (chk_addr && lat == 16) begin
                chk({name, "_last_addr"}, longint'(rom_addr), 7);
                chk({name, "_last_cs"}, longint'(rom_cs), 1);
            end
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, 18);
        chk({name, "_z1"}, longint'(z1), exp);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    vec_t vecs[9];
    vec_t v;
    int   seen;

    initial begin
        vecs[0] = '{16'sd0,      16'sd0,    16'sd0,     16'sd0,      0};
        vecs[1] = '{16'sd0,      16'sd0,    16'sd0,     16'sd1,      16069};
        vecs[2] = '{16'sd0,      16'sd0,    16'sd0,     -16'sd1,     -16069};
        vecs[3] = '{16'sd1,      16'sd0,    16'sd0,     16'sd0,      3195};
        vecs[4] = '{16'sd0,      16'sd0,    16'sd0,     16'sd32767,  526532923};
        vecs[5] = '{16'sd0,      16'sd1,    -16'sd2,    16'sd0,      -18143};
        vecs[6] = '{-16'sd32768, 16'sd0,    16'sd0,     -16'sd32768, -631242752};
        vecs[7] = '{16'sd32767,  16'sd32767, 16'sd32767, 16'sd32767, 1375886330};
        vecs[8] = '{16'sd100,    -16'sd200, 16'sd300,   -16'sd400,   -3841800};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x0 = 16'sd0; x1 = 16'sd0; x2 = 16'sd0; x3 = 16'sd0;
        #12;
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_rom_cs", longint'(rom_cs), 0);
        chk("rst_rom_addr", longint'(rom_addr), 0);
        chk("rst_z1", longint'(z1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            accept_vec(vecs[i]);
            wait_result($sformatf("vec%0d", i), vecs[i].z1, i == 3);
            consume();
        end

        // Backpressure: hold the result while a new vector waits at the input.
        v = '{16'sd0, 16'sd0, 16'sd0, 16'sd1, 16069};
        accept_vec(v);
        wait_result("bp_first", 16069, 1'b0);
        x0 = 16'sd0; x1 = 16'sd1; x2 = 16'sd0; x3 = 16'sd0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_z1_hold", longint'(z1), 16069);
            chk("bp_in_ready", longint'(in_ready), 0);
            chk("bp_out_valid", longint'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_ready", longint'(in_ready), 1);
        chk("bp_idle_valid", longint'(out_valid), 0);
        @(negedge clk);
        chk("bp_accepted", longint'(in_ready), 0);
        chk("bp_shift_cs", longint'(rom_cs), 1);
        in_valid = 1'b0;
        wait_result("bp_second", 9103, 1'b0);
        consume();

        // Reset in the middle of SHIFT discards the vector.
        v = '{16'sd0, 16'sd0, 16'sd0, 16'sd32767, 526532923};
        accept_vec(v);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", longint'(in_ready), 1);
        chk("mid_rst_out_valid", longint'(out_valid), 0);
        chk("mid_rst_rom_cs", longint'(rom_cs), 0);
        chk("mid_rst_rom_addr", longint'(rom_addr), 0);
        chk("mid_rst_z1", longint'(z1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mid_rst_no_valid", seen, 0);
        v = '{-16'sd5, 16'sd7, 16'sd0, 16'sd3, -15975 + 63721 + 48207};
        accept_vec(v);
        wait_result("post_rst", 95953, 1'b0);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
